// File: rtl/isa_bus_frontend_pkg.sv
// Shared constants and types for the ISA bus front end: decode windows,
// strobe indices, memory-cycle FSM states and the watchdog limit.
package isa_bus_frontend_pkg;

    // Default decode windows (CGA I/O block and framebuffer)
    localparam logic [19:0] IO_BASE_DEFAULT    = 20'h003d0;
    localparam logic [19:0] FB_BASE_DEFAULT    = 20'hb8000;
    localparam logic [4:0]  SLOT_PHASE_DEFAULT = 5'd17;

    // Watchdog: a memory cycle may sit in REQ/WAIT for at most 64 clocks
    localparam logic [5:0]  WD_LIMIT     = 6'd63;
    localparam logic [7:0]  TIMEOUT_DATA = 8'hff;

    // Index of each command strobe in the filter array
    localparam int STB_IOR  = 0;
    localparam int STB_IOW  = 1;
    localparam int STB_MEMR = 2;
    localparam int STB_MEMW = 3;
    localparam int NUM_STB  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } mem_state_e;

    // I/O window hit: 16-byte block at base, disabled during DMA (aen=1)
    function automatic logic io_window_hit(input logic [19:0] a,
                                           input logic        aen,
                                           input logic [19:0] base);
        return (a[19:4] == base[19:4]) && !aen;
    endfunction

    // Framebuffer hit: 32 KB window, only a[19:15] compared
    function automatic logic fb_window_hit(input logic [19:0] a,
                                           input logic [19:0] base);
        return a[19:15] == base[19:15];
    endfunction

endpackage

// File: rtl/isa_bus_frontend_strobe_filter.sv
// Two-flop synchroniser, FILTER_LEN-sample deglitch filter and falling-edge
// detector for one active-low ISA command strobe.
module isa_strobe_filter #(
    parameter int FILTER_LEN = 2
) (
    input  logic clk,
    input  logic reset_l,
    input  logic strobe_l,   // raw, asynchronous strobe
    output logic filt_l,     // filtered level, 1 = deasserted
    output logic accept      // one cycle on filtered 1->0 edge
);

    logic                  sync1_q, sync2_q;
    logic [FILTER_LEN-1:0] hist_q, hist_d;
    logic [FILTER_LEN+1:0] fill_q, fill_d;
    logic                  filt_q, filt_d;
    logic                  armed_q, armed_d;
    logic                  all_low, all_high;

    // Shift the newest synchronised sample into the history window
    if (FILTER_LEN == 1) begin : g_len_one
        assign hist_d = sync2_q;
    end else begin : g_len_many
        assign hist_d = {hist_q[FILTER_LEN-2:0], sync2_q};
    end

    assign all_low  = (hist_q == '0);
    assign all_high = &hist_q;

    // fill_q marks when the history holds real post-reset samples; the
    // filter only arms after it has seen the strobe genuinely deasserted,
    // so a strobe still low across reset is not taken as a new command.
    always_comb begin
        fill_d  = {fill_q[FILTER_LEN:0], 1'b1};
        filt_d  = filt_q;
        armed_d = armed_q;
        if (all_low) begin
            filt_d = 1'b0;
        end else if (all_high) begin
            filt_d = 1'b1;
        end
        if ((&fill_q) && all_high) begin
            armed_d = 1'b1;
        end
    end

    // Synchroniser, history and filter state
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= '1;
            fill_q  <= '0;
            filt_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= strobe_l;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            filt_q  <= filt_d;
            armed_q <= armed_d;
        end
    end

    assign filt_l = filt_q;
    assign accept = armed_q && filt_q && all_low;

endmodule

// File: rtl/isa_bus_frontend.sv
// ISA slot front end for the CGA core: filters command strobes, latches
// address/data on accept, decodes I/O and framebuffer windows, issues
// register-write strobes and VRAM requests, and drives IOCHRDY.
module isa_bus_frontend
    import isa_bus_frontend_pkg::*;
#(
    parameter logic [19:0] IO_BASE_ADDR     = IO_BASE_DEFAULT,
    parameter logic [19:0] FRAMEBUFFER_ADDR = FB_BASE_DEFAULT,
    parameter int          FILTER_LEN       = 2,
    parameter int          USE_BUS_WAIT     = 0,
    parameter logic [4:0]  SLOT_PHASE       = SLOT_PHASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic [19:0] bus_a,
    input  logic [7:0]  bus_d,
    input  logic        bus_aen,
    input  logic        bus_ior_l,
    input  logic        bus_iow_l,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic [4:0]  seq_phase,
    input  logic        vram_ack,
    input  logic [7:0]  vram_rdata,
    output logic [3:0]  io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_wr_stb,
    output logic        io_rd_act,
    output logic [14:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_req,
    output logic        vram_we,
    output logic [7:0]  mem_rdata,
    output logic        bus_dir,
    output logic        bus_rdy
);

    logic [NUM_STB-1:0] raw_l, filt_l, acc;
    logic               io_hit, mem_hit, mem_acc, mem_filt;
    logic               unused_iow_level;

    logic [3:0]  io_addr_q, io_addr_d;
    logic [7:0]  io_wdata_q, io_wdata_d;
    logic        io_wr_stb_q, io_wr_stb_d;
    logic        io_rd_act_q, io_rd_act_d;
    logic [14:0] vram_addr_q, vram_addr_d;
    logic [7:0]  vram_wdata_q, vram_wdata_d;
    logic        vram_we_q, vram_we_d;
    logic [7:0]  mem_rdata_q, mem_rdata_d;
    logic [5:0]  wd_q, wd_d;
    logic        abort_q, abort_d;
    mem_state_e  state_q, state_d;

    assign raw_l[STB_IOR]  = bus_ior_l;
    assign raw_l[STB_IOW]  = bus_iow_l;
    assign raw_l[STB_MEMR] = bus_memr_l;
    assign raw_l[STB_MEMW] = bus_memw_l;

    for (genvar gi = 0; gi < NUM_STB; gi++) begin : g_stb
        isa_strobe_filter #(
            .FILTER_LEN (FILTER_LEN)
        ) u_filter (
            .clk      (clk),
            .reset_l  (reset_l),
            .strobe_l (raw_l[gi]),
            .filt_l   (filt_l[gi]),
            .accept   (acc[gi])
        );
    end

    // An I/O write is fully described by its accept edge; its level is not needed
    assign unused_iow_level = filt_l[STB_IOW];

    assign io_hit  = io_window_hit(bus_a, bus_aen, IO_BASE_ADDR);
    assign mem_hit = fb_window_hit(bus_a, FRAMEBUFFER_ADDR);
    assign mem_acc = (acc[STB_MEMR] || acc[STB_MEMW]) && mem_hit;

    // Filtered level of whichever strobe owns the current memory cycle
    assign mem_filt = vram_we_q ? filt_l[STB_MEMW] : filt_l[STB_MEMR];

    // I/O path: latch address/data and form write strobe / read-active
    always_comb begin
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        io_wr_stb_d = acc[STB_IOW] && io_hit;
        io_rd_act_d = io_rd_act_q;
        if ((acc[STB_IOR] || acc[STB_IOW]) && io_hit) begin
            io_addr_d = bus_a[3:0];
        end
        if (acc[STB_IOW] && io_hit) begin
            io_wdata_d = bus_d;
        end
        if (acc[STB_IOR] && io_hit) begin
            io_rd_act_d = 1'b1;
        end else if (filt_l[STB_IOR]) begin
            io_rd_act_d = 1'b0;
        end
    end

    // Memory-cycle FSM: next state, latches, watchdog and abort tracking
    always_comb begin
        state_d      = state_q;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        vram_we_d    = vram_we_q;
        mem_rdata_d  = mem_rdata_q;
        abort_d      = abort_q;
        wd_d         = '0;
        case (state_q)
            ST_IDLE: begin
                // Accepts arriving in any other state are dropped
                if (mem_acc) begin
                    state_d     = ST_REQ;
                    vram_addr_d = bus_a[14:0];
                    vram_we_d   = acc[STB_MEMW];
                    abort_d     = 1'b0;
                    if (acc[STB_MEMW]) begin
                        vram_wdata_d = bus_d;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                wd_d = wd_q + 6'd1;
                if (mem_filt) begin
                    abort_d = 1'b1;
                end
                if (vram_ack) begin
                    // Early ack in REQ is legal and handled identically
                    if (!vram_we_q) begin
                        mem_rdata_d = vram_rdata;
                    end
                    state_d = (abort_q || mem_filt) ? ST_IDLE : ST_HOLD;
                end else if (wd_q == WD_LIMIT) begin
                    mem_rdata_d = TIMEOUT_DATA;
                    state_d     = (abort_q || mem_filt) ? ST_IDLE : ST_HOLD;
                end else if ((state_q == ST_REQ) && (seq_phase == SLOT_PHASE)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (mem_filt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register file for both paths
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            io_addr_q    <= '0;
            io_wdata_q   <= '0;
            io_wr_stb_q  <= 1'b0;
            io_rd_act_q  <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
            vram_we_q    <= 1'b0;
            mem_rdata_q  <= '0;
            wd_q         <= '0;
            abort_q      <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            io_addr_q    <= io_addr_d;
            io_wdata_q   <= io_wdata_d;
            io_wr_stb_q  <= io_wr_stb_d;
            io_rd_act_q  <= io_rd_act_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
            vram_we_q    <= vram_we_d;
            mem_rdata_q  <= mem_rdata_d;
            wd_q         <= wd_d;
            abort_q      <= abort_d;
            state_q      <= state_d;
        end
    end

    assign io_addr    = io_addr_q;
    assign io_wdata   = io_wdata_q;
    assign io_wr_stb  = io_wr_stb_q;
    assign io_rd_act  = io_rd_act_q;
    assign vram_addr  = vram_addr_q;
    assign vram_wdata = vram_wdata_q;
    assign vram_we    = vram_we_q;
    assign mem_rdata  = mem_rdata_q;
    assign vram_req   = (state_q == ST_REQ) || (state_q == ST_WAIT);

    // Read data direction follows the raw strobes so the buffer turns early
    assign bus_dir = (!bus_ior_l && io_hit) || (!bus_memr_l && mem_hit);

    // Wait state only while the host still holds the strobe for a live request
    assign bus_rdy = (USE_BUS_WAIT != 0) ? !(vram_req && !abort_q && !mem_filt) : 1'b1;

endmodule

// File: tb/tb_isa_bus_frontend.sv
// Directed testbench for isa_bus_frontend; one instance without and one with
// bus wait states, driven by identical stimulus.
module tb_isa_bus_frontend;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic [19:0] bus_a = '0;
    logic [7:0]  bus_d = '0;
    logic        bus_aen = 1'b0;
    logic        bus_ior_l = 1'b1, bus_iow_l = 1'b1, bus_memr_l = 1'b1, bus_memw_l = 1'b1;
    logic [4:0]  seq_phase = '0;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_rdata = '0;

    logic [3:0]  io_addr_0, io_addr_w;
    logic [7:0]  io_wdata_0, io_wdata_w;
    logic        io_wr_stb_0, io_wr_stb_w, io_rd_act_0, io_rd_act_w;
    logic [14:0] vram_addr_0, vram_addr_w;
    logic [7:0]  vram_wdata_0, vram_wdata_w, mem_rdata_0, mem_rdata_w;
    logic        vram_req_0, vram_req_w, vram_we_0, vram_we_w;
    logic        bus_dir_0, bus_dir_w, bus_rdy_0, bus_rdy_w;

    int n_tests = 0;
    int n_fail  = 0;

    isa_bus_frontend #(.FILTER_LEN(2), .USE_BUS_WAIT(0)) dut (
        .clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_d(bus_d), .bus_aen(bus_aen),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .seq_phase(seq_phase), .vram_ack(vram_ack),
        .vram_rdata(vram_rdata), .io_addr(io_addr_0), .io_wdata(io_wdata_0),
        .io_wr_stb(io_wr_stb_0), .io_rd_act(io_rd_act_0), .vram_addr(vram_addr_0),
        .vram_wdata(vram_wdata_0), .vram_req(vram_req_0), .vram_we(vram_we_0),
        .mem_rdata(mem_rdata_0), .bus_dir(bus_dir_0), .bus_rdy(bus_rdy_0)
    );

    isa_bus_frontend #(.FILTER_LEN(2), .USE_BUS_WAIT(1)) dut_w (
        .clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_d(bus_d), .bus_aen(bus_aen),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .seq_phase(seq_phase), .vram_ack(vram_ack),
        .vram_rdata(vram_rdata), .io_addr(io_addr_w), .io_wdata(io_wdata_w),
        .io_wr_stb(io_wr_stb_w), .io_rd_act(io_rd_act_w), .vram_addr(vram_addr_w),
        .vram_wdata(vram_wdata_w), .vram_req(vram_req_w), .vram_we(vram_we_w),
        .mem_rdata(mem_rdata_w), .bus_dir(bus_dir_w), .bus_rdy(bus_rdy_w)
    );

    always #5 clk = ~clk;

    // Sequencer phase advances on the falling edge so it is stable at posedge
    initial begin
        forever begin
            @(negedge clk);
            seq_phase = seq_phase + 5'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold iow low for low_cycles clocks and count write strobes seen
    task automatic iow_pulse(input logic [19:0] a, input logic [7:0] d, input int low_cycles,
                             output int pulses, output int first);
        bus_a = a;
        bus_d = d;
        bus_iow_l = 1'b0;
        pulses = 0;
        first = -1;
        for (int i = 1; i <= low_cycles + 8; i++) begin
            if (i == low_cycles + 1) bus_iow_l = 1'b1;
            tick();
            if (io_wr_stb_0) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    // Wait (bounded) for vram_req; returns the sample index, -1 if never
    task automatic wait_req(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (vram_req_0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_phase17(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (seq_phase == 5'd17) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    int   pulses, first, cyc, cnt;
    logic seen;

    initial begin
        // Reset state
        tick(2);
        check("rst_vram_req", vram_req_0, 0);
        check("rst_bus_rdy_w", bus_rdy_w, 1);
        check("rst_io_wr_stb", io_wr_stb_0, 0);
        check("rst_mem_rdata", mem_rdata_0, 8'h00);
        reset_l = 1'b1;
        tick(10);

        // I/O write to 3d8, one strobe 5 clocks after the raw edge
        iow_pulse(20'h003d8, 8'h29, 20, pulses, first);
        check("iow_pulses", pulses, 1);
        check("iow_latency", first, 5);
        check("iow_addr", io_addr_0, 4'h8);
        check("iow_wdata", io_wdata_0, 8'h29);

        // Single-clock glitch is rejected
        iow_pulse(20'h003d3, 8'h77, 1, pulses, first);
        check("glitch_pulses", pulses, 0);
        check("glitch_addr_kept", io_addr_0, 4'h8);
        check("glitch_no_req", vram_req_0, 0);

        // DMA cycle and out-of-window address are not decoded
        bus_aen = 1'b1;
        iow_pulse(20'h003d2, 8'h11, 10, pulses, first);
        bus_aen = 1'b0;
        check("aen_pulses", pulses, 0);
        iow_pulse(20'h003e8, 8'h22, 10, pulses, first);
        check("outwin_pulses", pulses, 0);

        // I/O read to 3d5
        bus_a = 20'h003d5;
        bus_ior_l = 1'b0;
        tick();
        check("ior_bus_dir", bus_dir_0, 1);
        tick(6);
        check("ior_rd_act", io_rd_act_0, 1);
        check("ior_addr", io_addr_0, 4'h5);
        bus_ior_l = 1'b1;
        tick(8);
        check("ior_rd_act_off", io_rd_act_0, 0);
        check("ior_bus_dir_off", bus_dir_0, 0);

        // Memory write to b8010, acked in the slot phase
        bus_a = 20'hb8010;
        bus_d = 8'h41;
        bus_memw_l = 1'b0;
        wait_req(cyc);
        check("memw_req_lat", cyc, 5);
        check("memw_addr", vram_addr_0, 15'h0010);
        check("memw_we", vram_we_0, 1);
        check("memw_wdata", vram_wdata_0, 8'h41);
        check("memw_rdy_wait", bus_rdy_w, 0);
        check("memw_rdy_nowait", bus_rdy_0, 1);
        wait_phase17(seen);
        check("memw_phase_seen", seen, 1);
        vram_ack = 1'b1;
        check("memw_req_held", vram_req_0, 1);
        check("memw_rdy_still_low", bus_rdy_w, 0);
        tick();
        vram_ack = 1'b0;
        check("memw_req_done", vram_req_0, 0);
        check("memw_rdy_done", bus_rdy_w, 1);
        bus_memw_l = 1'b1;
        tick(8);

        // Memory read from b8000, data returned on ack
        bus_a = 20'hb8000;
        bus_memr_l = 1'b0;
        tick();
        check("memr_bus_dir", bus_dir_0, 1);
        wait_req(cyc);
        check("memr_req_lat", cyc, 4);
        check("memr_we", vram_we_0, 0);
        wait_phase17(seen);
        vram_ack = 1'b1;
        vram_rdata = 8'h5a;
        tick();
        vram_ack = 1'b0;
        vram_rdata = 8'h00;
        check("memr_rdata", mem_rdata_0, 8'h5a);
        check("memr_bus_dir_held", bus_dir_0, 1);
        bus_memr_l = 1'b1;
        tick(8);
        check("memr_bus_dir_off", bus_dir_0, 0);

        // Memory read with no ack: watchdog frees the bus after 64 clocks
        bus_memr_l = 1'b0;
        wait_req(cyc);
        cnt = (cyc > 0) ? 1 : 0;
        for (int i = 0; i < 100 && cyc > 0; i++) begin
            tick();
            if (vram_req_0) cnt++;
            else break;
        end
        check("wd_req_cycles", cnt, 64);
        check("wd_rdy", bus_rdy_w, 1);
        check("wd_rdata", mem_rdata_0, 8'hff);
        bus_memr_l = 1'b1;
        tick(8);

        // Reset during WAIT, strobe held low across it
        bus_memr_l = 1'b0;
        wait_req(cyc);
        wait_phase17(seen);
        reset_l = 1'b0;
        #1;
        check("rst_mid_req", vram_req_0, 0);
        check("rst_mid_rdy", bus_rdy_w, 1);
        tick(3);
        reset_l = 1'b1;
        tick(15);
        check("rst_no_reaccept", vram_req_0, 0);
        bus_memr_l = 1'b1;
        tick(8);
        check("rst_released_idle", vram_req_0, 0);

        // Fresh read after release is accepted; early ack straight from REQ
        bus_memr_l = 1'b0;
        wait_req(cyc);
        check("rearm_req_lat", cyc, 5);
        vram_ack = 1'b1;
        vram_rdata = 8'h3c;
        tick();
        vram_ack = 1'b0;
        check("early_ack_req", vram_req_0, 0);
        check("early_ack_rdata", mem_rdata_0, 8'h3c);
        bus_memr_l = 1'b1;
        tick(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
